// File: rtl/wb_merge_unit_pkg.sv
// Shared widths and entry-layout helpers for the writeback merge unit.
// Entry layout, MSB first: {we, rd, data, inst, inst_addr}.
package wb_merge_unit_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned NUM_REGS     = 32;
    localparam int unsigned INSTRET_W    = 64;
    localparam int unsigned INST_W       = 32;
    localparam int unsigned TAG_W        = 1 + REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    function automatic int unsigned entry_width(input int unsigned xlen);
        return 1 + REG_IDX_W + xlen + INST_W + xlen;
    endfunction

endpackage

// File: rtl/wb_merge_unit_if.sv
// Producer-side and regfile/retire-side signals of the writeback merge unit.
// Channel i occupies slice i of every packed per-channel vector.
interface wb_merge_unit_if
    import wb_merge_unit_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned XLEN   = XLEN_DEFAULT
);
    logic [NUM_CH-1:0]           ch_valid;
    logic [NUM_CH-1:0]           ch_ready;
    logic [NUM_CH-1:0]           ch_we;
    logic [NUM_CH*REG_IDX_W-1:0] ch_rd_index;
    logic [NUM_CH*XLEN-1:0]      ch_rd_content;
    logic [NUM_CH*INST_W-1:0]    ch_inst;
    logic [NUM_CH*XLEN-1:0]      ch_inst_addr;

    logic                        rd_write_en;
    logic [REG_IDX_W-1:0]        rd_index;
    logic [XLEN-1:0]             rd_reg_content;
    logic                        retire_valid;
    logic [INST_W-1:0]           retire_inst;
    logic [XLEN-1:0]             retire_inst_addr;
    logic [INSTRET_W-1:0]        instret;
    logic [NUM_REGS-1:0]         busy_mask;

    modport master (
        output ch_valid, ch_we, ch_rd_index, ch_rd_content, ch_inst, ch_inst_addr,
        input  ch_ready, rd_write_en, rd_index, rd_reg_content, retire_valid,
               retire_inst, retire_inst_addr, instret, busy_mask
    );

    modport slave (
        input  ch_valid, ch_we, ch_rd_index, ch_rd_content, ch_inst, ch_inst_addr,
        output ch_ready, rd_write_en, rd_index, rd_reg_content, retire_valid,
               retire_inst, retire_inst_addr, instret, busy_mask
    );

endinterface

// File: rtl/wb_merge_unit_fifo.sv
// Per-channel synchronous FIFO with flush; exposes per-slot tags and occupancy
// so the parent can build a busy mask over every queued entry.
module wb_merge_unit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned TAG_W = 1,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [CntW-1:0]          o_count,
    output logic [DEPTH*TAG_W-1:0]   o_tags,
    output logic [DEPTH-1:0]         o_occupied
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;
    logic [PtrW-1:0]  w_off;

    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full & ~i_flush;
    assign w_pop   = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Slot j is live when its distance from the read pointer is below the count.
    always_comb begin
        w_off      = '0;
        o_occupied = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            w_off         = PtrW'(j) - r_rd_ptr;
            o_occupied[j] = ({1'b0, w_off} < r_count);
        end
    end

    for (genvar j = 0; j < DEPTH; j++) begin : g_tag
        assign o_tags[j*TAG_W +: TAG_W] = r_mem[j][WIDTH-1 -: TAG_W];
    end

endmodule

// File: rtl/wb_merge_unit.sv
// Writeback merge: per-channel FIFOs drained one entry per cycle onto the
// regfile write port under round-robin arbitration, plus retire and instret.
module wb_merge_unit
    import wb_merge_unit_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned XLEN   = XLEN_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_flush,
    wb_merge_unit_if.slave bus_if
);
    localparam int unsigned EntryW = entry_width(XLEN);
    localparam int unsigned GrantW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]        w_push;
    logic [NUM_CH-1:0]        w_pop;
    logic [NUM_CH-1:0]        w_full;
    logic [NUM_CH-1:0]        w_empty;
    logic [NUM_CH*CntW-1:0]   w_count;
    logic                     w_unused_count;
    logic [EntryW-1:0]        w_head [NUM_CH];
    logic [DEPTH*TAG_W-1:0]   w_tags [NUM_CH];
    logic [DEPTH-1:0]         w_occ  [NUM_CH];

    logic                     w_pop_any;
    logic [GrantW-1:0]        w_grant;
    logic [GrantW-1:0]        w_gidx;
    int unsigned              w_idx;
    logic [EntryW-1:0]        w_sel;
    logic                     w_sel_we;
    reg_idx_t                 w_sel_rd;
    logic [XLEN-1:0]          w_sel_data;
    logic [INST_W-1:0]        w_sel_inst;
    logic [XLEN-1:0]          w_sel_addr;
    logic                     w_wen;
    logic [NUM_REGS-1:0]      w_busy;

    logic [GrantW-1:0]        r_last_grant;
    logic                     r_rd_write_en;
    reg_idx_t                 r_rd_index;
    logic [XLEN-1:0]          r_rd_content;
    logic                     r_retire_valid;
    logic [INST_W-1:0]        r_retire_inst;
    logic [XLEN-1:0]          r_retire_addr;
    logic [INSTRET_W-1:0]     r_instret;

    assign bus_if.ch_ready = ~w_full;
    assign w_push          = bus_if.ch_valid & ~w_full & {NUM_CH{~i_flush}};
    assign w_unused_count  = ^w_count;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        wb_merge_unit_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (EntryW),
            .TAG_W (TAG_W)
        ) u_fifo (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_flush    (i_flush),
            .i_push     (w_push[g]),
            .i_pop      (w_pop[g]),
            .i_data     ({bus_if.ch_we[g],
                          bus_if.ch_rd_index[g*REG_IDX_W +: REG_IDX_W],
                          bus_if.ch_rd_content[g*XLEN +: XLEN],
                          bus_if.ch_inst[g*INST_W +: INST_W],
                          bus_if.ch_inst_addr[g*XLEN +: XLEN]}),
            .o_data     (w_head[g]),
            .o_full     (w_full[g]),
            .o_empty    (w_empty[g]),
            .o_count    (w_count[g*CntW +: CntW]),
            .o_tags     (w_tags[g]),
            .o_occupied (w_occ[g])
        );
    end

    // Search starts one past the last winner so every channel gets a turn.
    always_comb begin
        w_pop_any = 1'b0;
        w_grant   = '0;
        w_gidx    = '0;
        w_idx     = 0;
        w_sel     = '0;
        w_pop     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_idx  = (32'(r_last_grant) + 32'd1 + k) % NUM_CH;
            w_gidx = GrantW'(w_idx);
            if (!w_pop_any && !w_empty[w_gidx]) begin
                w_pop_any     = 1'b1;
                w_grant       = w_gidx;
                w_sel         = w_head[w_gidx];
                w_pop[w_gidx] = ~i_flush;
            end
        end
    end

    assign w_sel_we   = w_sel[EntryW-1];
    assign w_sel_rd   = w_sel[EntryW-2 -: REG_IDX_W];
    assign w_sel_data = w_sel[2*XLEN+INST_W-1 -: XLEN];
    assign w_sel_inst = w_sel[XLEN+INST_W-1 -: INST_W];
    assign w_sel_addr = w_sel[XLEN-1:0];
    assign w_wen      = w_sel_we & (w_sel_rd != '0);

    always_comb begin
        w_busy = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (w_occ[c][j] && w_tags[c][j*TAG_W + TAG_W - 1] &&
                    (w_tags[c][j*TAG_W +: REG_IDX_W] != '0)) begin
                    w_busy[w_tags[c][j*TAG_W +: REG_IDX_W]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant   <= '0;
            r_rd_write_en  <= 1'b0;
            r_rd_index     <= '0;
            r_rd_content   <= '0;
            r_retire_valid <= 1'b0;
            r_retire_inst  <= '0;
            r_retire_addr  <= '0;
            r_instret      <= '0;
        end else if (i_flush) begin
            r_last_grant   <= '0;
            r_rd_write_en  <= 1'b0;
            r_rd_index     <= '0;
            r_rd_content   <= '0;
            r_retire_valid <= 1'b0;
            r_retire_inst  <= '0;
            r_retire_addr  <= '0;
        end else begin
            r_retire_valid <= w_pop_any;
            r_rd_write_en  <= w_pop_any & w_wen;
            r_rd_index     <= (w_pop_any && w_wen) ? w_sel_rd : '0;
            r_rd_content   <= (w_pop_any && w_wen) ? w_sel_data : '0;
            r_retire_inst  <= w_pop_any ? w_sel_inst : '0;
            r_retire_addr  <= w_pop_any ? w_sel_addr : '0;
            if (w_pop_any) begin
                r_last_grant <= w_grant;
                r_instret    <= r_instret + 1'b1;
            end
        end
    end

    assign bus_if.rd_write_en      = r_rd_write_en;
    assign bus_if.rd_index         = r_rd_index;
    assign bus_if.rd_reg_content   = r_rd_content;
    assign bus_if.retire_valid     = r_retire_valid;
    assign bus_if.retire_inst      = r_retire_inst;
    assign bus_if.retire_inst_addr = r_retire_addr;
    assign bus_if.instret          = r_instret;
    assign bus_if.busy_mask        = w_busy;

endmodule

// File: tb/tb_wb_merge_unit.sv
// Directed bench for wb_merge_unit: per-channel expected-retire queues are filled
// when an entry is accepted and drained as retires appear on the outputs.
module tb_wb_merge_unit;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned XLEN   = 32;

    typedef struct {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] inst;
        logic [31:0] addr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          order[$];
    int          seq_ctr[2];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_acc  = '0;

    always #5 clk = ~clk;

    wb_merge_unit_if #(.NUM_CH(NUM_CH), .XLEN(XLEN)) bus ();

    wb_merge_unit #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .XLEN   (XLEN)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .bus_if  (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] busy_model();
        logic [31:0] m = '0;
        foreach (sb0[k]) if (sb0[k].wr) m[sb0[k].rd] = 1'b1;
        foreach (sb1[k]) if (sb1[k].wr) m[sb1[k].rd] = 1'b1;
        return m;
    endfunction

    // Present an entry on channel ch; it is expected only if accepted this edge.
    task automatic drive(input int ch, input logic we, input logic [4:0] rd,
                         input logic [31:0] data);
        exp_t e;
        e.inst = {4'hA, 4'(ch), 24'(seq_ctr[ch])};
        e.addr = 32'h1000_0000 + 32'(ch) * 32'h0010_0000 + 32'(seq_ctr[ch]) * 32'd4;
        e.wr   = we && (rd != 5'd0);
        e.rd   = e.wr ? rd : 5'd0;
        e.data = e.wr ? data : 32'd0;
        bus.ch_valid[ch]               = 1'b1;
        bus.ch_we[ch]                  = we;
        bus.ch_rd_index[ch*5 +: 5]     = rd;
        bus.ch_rd_content[ch*32 +: 32] = data;
        bus.ch_inst[ch*32 +: 32]       = e.inst;
        bus.ch_inst_addr[ch*32 +: 32]  = e.addr;
        if (bus.ch_ready[ch] && !flush) begin
            if (ch == 0) sb0.push_back(e);
            else         sb1.push_back(e);
            seq_ctr[ch]++;
            exp_acc++;
        end
    endtask

    task automatic idle();
        bus.ch_valid = '0;
    endtask

    // One clock; sample on the falling edge and compare against the scoreboard.
    task automatic cyc();
        exp_t e;
        int   ch;
        int   avail;
        @(posedge clk);
        @(negedge clk);
        if (bus.retire_valid) begin
            ch    = int'(bus.retire_inst[27:24]);
            avail = (ch == 0) ? sb0.size() : (ch == 1) ? sb1.size() : 0;
            order.push_back(ch);
            chk("retire_expected", 64'(avail > 0), 64'd1);
            if (avail > 0) begin
                e = (ch == 0) ? sb0.pop_front() : sb1.pop_front();
                chk("retire_inst", 64'(bus.retire_inst), 64'(e.inst));
                chk("retire_addr", 64'(bus.retire_inst_addr), 64'(e.addr));
                chk("rd_write_en", 64'(bus.rd_write_en), 64'(e.wr));
                chk("rd_index", 64'(bus.rd_index), 64'(e.rd));
                chk("rd_reg_content", 64'(bus.rd_reg_content), 64'(e.data));
            end
        end else begin
            chk("idle_outputs", 64'(|{bus.rd_write_en, bus.rd_index, bus.rd_reg_content,
                                       bus.retire_inst, bus.retire_inst_addr}), 64'd0);
        end
        chk("busy_mask", 64'(bus.busy_mask), 64'(busy_model()));
        chk("ch_ready", 64'(bus.ch_ready), 64'({sb1.size() < DEPTH, sb0.size() < DEPTH}));
        chk("instret", bus.instret, exp_acc - 64'(sb0.size()) - 64'(sb1.size()));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && (sb0.size() + sb1.size()) > 0; i++) cyc();
        chk("drained", 64'(sb0.size() + sb1.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_full;
        seq_ctr[0] = 0;
        seq_ctr[1] = 0;
        bus.ch_valid      = '0;
        bus.ch_we         = '0;
        bus.ch_rd_index   = '0;
        bus.ch_rd_content = '0;
        bus.ch_inst       = '0;
        bus.ch_inst_addr  = '0;

        // Reset state
        #12;
        chk("rst_outputs", 64'(|{bus.retire_valid, bus.rd_write_en, bus.rd_index,
                                  bus.rd_reg_content, bus.retire_inst}), 64'd0);
        chk("rst_instret", bus.instret, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 64'(bus.ch_ready), 64'd3);
        chk("busy_after_reset", 64'(bus.busy_mask), 64'd0);
        @(negedge clk);

        // Single channel write
        drive(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        cyc();
        idle();
        chk("t1_busy5", 64'(bus.busy_mask), 64'h20);
        chk("t1_no_retire_yet", 64'(bus.retire_valid), 64'd0);
        cyc();
        chk("t1_retire_valid", 64'(bus.retire_valid), 64'd1);
        chk("t1_wen", 64'(bus.rd_write_en), 64'd1);
        chk("t1_rd", 64'(bus.rd_index), 64'd5);
        chk("t1_data", 64'(bus.rd_reg_content), 64'hDEAD_BEEF);
        chk("t1_instret", bus.instret, 64'd1);
        chk("t1_busy_clear", 64'(bus.busy_mask), 64'd0);

        // x0 target and we=0
        drive(0, 1'b1, 5'd0, 32'h1111_1111);
        cyc();
        chk("t2_busy_x0", 64'(bus.busy_mask), 64'd0);
        drive(0, 1'b0, 5'd7, 32'h2222_2222);
        cyc();
        idle();
        chk("t2_busy_nowe", 64'(bus.busy_mask), 64'd0);
        chk("t2_a_retire", 64'({bus.retire_valid, bus.rd_write_en, bus.rd_index}), 64'h40);
        chk("t2_a_data", 64'(bus.rd_reg_content), 64'd0);
        cyc();
        chk("t2_b_retire", 64'({bus.retire_valid, bus.rd_write_en, bus.rd_index}), 64'h40);
        chk("t2_b_data", 64'(bus.rd_reg_content), 64'd0);
        chk("t2_instret", bus.instret, 64'd3);

        // Back-pressure with both channels streaming
        saw_full = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b1, 5'(1 + seq_ctr[0] % 15), $urandom);
            drive(1, 1'b1, 5'(16 + seq_ctr[1] % 15), $urandom);
            cyc();
            if (!bus.ch_ready[0]) saw_full = 1'b1;
        end
        idle();
        chk("t3_ch0_filled", 64'(saw_full), 64'd1);
        drain(30);

        // Round-robin: ch1 wins last, so ch0 leads the alternation
        drive(1, 1'b1, 5'd3, 32'h3333_0000);
        cyc();
        idle();
        cyc();
        order.delete();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 5'(8 + i), 32'h0A00_0000 + 32'(i));
            drive(1, 1'b1, 5'(20 + i), 32'h0B00_0000 + 32'(i));
            cyc();
        end
        idle();
        drain(12);
        chk("t4_rr_count", 64'(order.size()), 64'd6);
        foreach (order[k]) chk("t4_rr_order", 64'(order[k]), 64'(k % 2));

        // Only ch1 busy: retires every cycle
        order.delete();
        drive(1, 1'b1, 5'd12, 32'hC000_0001);
        cyc();
        drive(1, 1'b1, 5'd13, 32'hC000_0002);
        cyc();
        chk("t4_solo_r1", 64'(bus.retire_valid), 64'd1);
        drive(1, 1'b1, 5'd14, 32'hC000_0003);
        cyc();
        idle();
        chk("t4_solo_r2", 64'(bus.retire_valid), 64'd1);
        cyc();
        chk("t4_solo_r3", 64'(bus.retire_valid), 64'd1);
        cyc();
        chk("t4_solo_done", 64'(bus.retire_valid), 64'd0);
        chk("t4_solo_count", 64'(order.size()), 64'd3);
        foreach (order[k]) chk("t4_solo_ch", 64'(order[k]), 64'd1);

        // Flush beats a concurrent push
        drive(0, 1'b1, 5'd9, 32'h5555_0001);
        drive(1, 1'b1, 5'd10, 32'h5555_0002);
        cyc();
        drive(0, 1'b1, 5'd11, 32'h5555_0003);
        drive(1, 1'b1, 5'd17, 32'h5555_0004);
        cyc();
        idle();
        chk("t5_queued", 64'(sb0.size() + sb1.size()), 64'd3);
        flush = 1'b1;
        drive(0, 1'b1, 5'd18, 32'h5555_0005);
        exp_acc = exp_acc - 64'(sb0.size()) - 64'(sb1.size());
        sb0.delete();
        sb1.delete();
        cyc();
        flush = 1'b0;
        idle();
        chk("t5_retire_valid", 64'(bus.retire_valid), 64'd0);
        chk("t5_busy", 64'(bus.busy_mask), 64'd0);
        chk("t5_instret", bus.instret, exp_acc);
        for (int i = 0; i < 3; i++) cyc();

        // Async reset with entries queued
        drive(0, 1'b1, 5'd21, 32'h6666_0001);
        drive(1, 1'b1, 5'd22, 32'h6666_0002);
        cyc();
        drive(0, 1'b1, 5'd23, 32'h6666_0003);
        drive(1, 1'b1, 5'd24, 32'h6666_0004);
        cyc();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", 64'(|{bus.retire_valid, bus.rd_write_en, bus.rd_index,
                                     bus.rd_reg_content, bus.retire_inst_addr}), 64'd0);
        chk("t6_rst_busy", 64'(bus.busy_mask), 64'd0);
        chk("t6_rst_instret", bus.instret, 64'd0);
        sb0.delete();
        sb1.delete();
        exp_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // instret wrap
        force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.r_instret;
        exp_acc = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("t6_preset", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(0, 1'b1, 5'd4, 32'h7777_7777);
        cyc();
        idle();
        cyc();
        chk("t6_wrap_retire", 64'(bus.retire_valid), 64'd1);
        chk("t6_wrap", bus.instret, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
